wb_gpio_responder: RTL and testbench



---
 rtl/wb_gpio_responder.sv | 156 +++++++++++++++
 tb/tb_wb_gpio_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_responder.sv
// wb_gpio_responder
//   Wishbone B3 classic-cycle slave exposing a WIDTH-bit GPIO port with
//   per-pin direction, a 2-flop input synchroniser, selectable edge
//   detection, sticky write-1-to-clear interrupt status and a registered
//   level interrupt.
//
// Ports
//   wb_clk_i, wb_rst_n_i    clock, asynchronous active-low reset
//   wb_adr_i[4:2]           word index of the register being accessed
//   wb_dat_i, wb_sel_i[0]   write data and low-byte write enable
//   wb_we_i, wb_cyc_i, wb_stb_i  request qualifiers
//   wb_dat_o, wb_ack_o      registered read data and one-cycle acknowledge
//   gpio_i                  asynchronous pin inputs
//   gpio_o, gpio_dir_o      output data and drive enables (1 = output)
//   irq_o                   level interrupt, OR of enabled status bits
//
// Register map (word index)
//   0 OUT  1 DIR  2 IN (ro)  3 IRQ_EN  4 IRQ_STAT (W1C)  5 EDGE (1=rise)
//   6,7 read as zero, writes acknowledged and dropped
module wb_gpio_responder #(
  parameter int WIDTH = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_dir_o,
  output logic             irq_o
);

  localparam logic [2:0] REG_OUT  = 3'd0;
  localparam logic [2:0] REG_DIR  = 3'd1;
  localparam logic [2:0] REG_IN   = 3'd2;
  localparam logic [2:0] REG_EN   = 3'd3;
  localparam logic [2:0] REG_STAT = 3'd4;
  localparam logic [2:0] REG_EDGE = 3'd5;

  logic [WIDTH-1:0] out_q,  out_d;
  logic [WIDTH-1:0] dir_q,  dir_d;
  logic [WIDTH-1:0] en_q,   en_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic             ack_q,  ack_d;
  logic [31:0]      dat_q,  dat_d;
  logic             irq_q,  irq_d;

  logic             req;
  logic             wr_en;
  logic [2:0]       idx;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] ev;
  logic [31:0]      rd_data;

  // Address bits outside [4:2], data bits above WIDTH and sel[3:1] carry
  // no meaning for this block; fold them into a sink so nothing dangles.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{wb_adr_i, wb_dat_i, wb_sel_i};

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Holding ack blocks re-acceptance, so a strobe held through the ack
  // cycle yields exactly one acknowledge.
  assign req   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_en = req & wb_we_i & wb_sel_i[0];
  assign idx   = wb_adr_i[4:2];
  assign wdata = wb_dat_i[WIDTH-1:0];

  // s2 is the settled pin value, s3 its previous-cycle copy.
  assign ev = (edge_q & s2_q & ~s3_q) | (~edge_q & ~s2_q & s3_q);

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    en_d   = en_q;
    edge_d = edge_q;
    w1c    = '0;
    if (wr_en) begin
      case (idx)
        REG_OUT:  out_d  = wdata;
        REG_DIR:  dir_d  = wdata;
        REG_EN:   en_d   = wdata;
        REG_STAT: w1c    = wdata;
        REG_EDGE: edge_d = wdata;
        default:  ;
      endcase
    end
    // A new event on the same cycle as a clear keeps the bit set.
    stat_d = (stat_q & ~w1c) | ev;
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      REG_OUT:  rd_data = zext(out_q);
      REG_DIR:  rd_data = zext(dir_q);
      REG_IN:   rd_data = zext(s2_q);
      REG_EN:   rd_data = zext(en_q);
      REG_STAT: rd_data = zext(stat_q);
      REG_EDGE: rd_data = zext(edge_q);
      default:  rd_data = '0;
    endcase
    ack_d = req;
    dat_d = (req & ~wb_we_i) ? rd_data : '0;
    irq_d = |(stat_q & en_q);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      out_q  <= '0;
      dir_q  <= '0;
      en_q   <= '0;
      stat_q <= '0;
      edge_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      stat_q <= stat_d;
      edge_q <= edge_d;
      s1_q   <= gpio_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      irq_q  <= irq_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign gpio_o     = out_q;
  assign gpio_dir_o = dir_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_gpio_responder.sv
// Directed bench for wb_gpio_responder: expected read data is queued when a
// read is issued and popped when the acknowledge arrives.
module tb_wb_gpio_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_o;
  logic        ack;
  logic [7:0]  gpio;
  logic [7:0]  gpio_o;
  logic [7:0]  dir_o;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  wb_gpio_responder #(.WIDTH(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat),
    .wb_sel_i   (sel),
    .wb_we_i    (we),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_dat_o   (dat_o),
    .wb_ack_o   (ack),
    .gpio_i     (gpio),
    .gpio_o     (gpio_o),
    .gpio_dir_o (dir_o),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus request; returns one cycle after the ack so ack-low is checked.
  task automatic bus(input string tag, input logic [2:0] idx, input logic w,
                     input logic [31:0] d, input logic [3:0] s);
    int n;
    logic [31:0] e;
    n = 0;
    adr = {27'd0, idx, 2'b00};
    dat = d;
    sel = s;
    we  = w;
    cyc = 1'b1;
    stb = 1'b1;
    do begin
      tick();
      n++;
    end while (ack !== 1'b1 && n < 4);
    chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    if (!w) begin
      e = exp_q.pop_front();
      chk(tag, dat_o, e);
    end
    tick();
    chk({tag, "_ack_low"}, {31'd0, ack}, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [2:0] idx, input logic [31:0] e);
    exp_q.push_back(e);
    bus(tag, idx, 1'b0, 32'd0, 4'h1);
  endtask

  task automatic wr(input string tag, input logic [2:0] idx, input logic [31:0] d,
                    input logic [3:0] s);
    bus(tag, idx, 1'b1, d, s);
  endtask

  initial begin
    int nacks;
    rst_n = 1'b0;
    adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    gpio = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst_ack",  {31'd0, ack}, 32'd0);
    chk("rst_dat",  dat_o, 32'd0);
    chk("rst_out",  {24'd0, gpio_o}, 32'd0);
    chk("rst_dir",  {24'd0, dir_o}, 32'd0);
    chk("rst_irq",  {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) rd($sformatf("rst_rd%0d", i), i[2:0], 32'd0);
    chk("rst_irq2", {31'd0, irq}, 32'd0);

    // OUT / DIR writes, byte select, width truncation, read-only/ignored words
    wr("w_out", 3'd0, 32'h0000_00A5, 4'h1);
    wr("w_dir", 3'd1, 32'h0000_00FF, 4'h1);
    chk("gpio_o_a5", {24'd0, gpio_o}, 32'hA5);
    chk("dir_ff",    {24'd0, dir_o}, 32'hFF);
    rd("rd_out", 3'd0, 32'hA5);
    rd("rd_dir", 3'd1, 32'hFF);
    wr("w_out_sel2", 3'd0, 32'h0000_0000, 4'h2);
    chk("gpio_o_sel2", {24'd0, gpio_o}, 32'hA5);
    wr("w_out_wide", 3'd0, 32'hFFFF_FF5A, 4'h1);
    chk("gpio_o_5a", {24'd0, gpio_o}, 32'h5A);
    rd("rd_out_wide", 3'd0, 32'h5A);
    wr("w_in", 3'd2, 32'hFF, 4'h1);
    rd("rd_in_ro", 3'd2, 32'h00);
    wr("w_w6", 3'd6, 32'hFF, 4'h1);
    rd("rd_w6", 3'd6, 32'h00);
    rd("rd_w7", 3'd7, 32'h00);

    // Rising edge on pin 0 with interrupt enabled
    wr("w_edge1", 3'd5, 32'h01, 4'h1);
    wr("w_en1",   3'd3, 32'h01, 4'h1);
    gpio = 8'h01;
    tick();
    tick();
    tick();
    chk("irq_t2", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_t3", {31'd0, irq}, 32'd1);
    rd("rd_in1",   3'd2, 32'h01);
    rd("rd_stat1", 3'd4, 32'h01);
    wr("w1c_0", 3'd4, 32'h01, 4'h1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd("rd_stat_clr", 3'd4, 32'h00);

    // Falling edge on pin 3 while disabled, then enable
    wr("w_en0",   3'd3, 32'h00, 4'h1);
    wr("w_edge0", 3'd5, 32'h00, 4'h1);
    gpio = 8'h09;
    repeat (4) tick();
    rd("rd_stat_rise_ign", 3'd4, 32'h00);
    gpio = 8'h01;
    repeat (5) tick();
    rd("rd_stat8", 3'd4, 32'h08);
    chk("irq_dis", {31'd0, irq}, 32'd0);
    wr("w_en8", 3'd3, 32'h08, 4'h1);
    chk("irq_en_late", {31'd0, irq}, 32'd1);
    wr("w1c_3", 3'd4, 32'h08, 4'h1);
    chk("irq_clr3", {31'd0, irq}, 32'd0);

    // Strobe held through the ack cycle: one acknowledge only
    exp_q.push_back(32'h5A);
    adr = 32'h0; we = 1'b0; sel = 4'h1; cyc = 1'b1; stb = 1'b1;
    nacks = 0;
    tick();
    nacks += int'(ack);
    chk("hold_rd", dat_o, exp_q.pop_front());
    tick();
    nacks += int'(ack);
    cyc = 1'b0; stb = 1'b0;
    tick();
    nacks += int'(ack);
    chk("hold_one_ack", nacks, 32'd1);

    // Rising event coincident with W1C of the same bit
    wr("w_edge_r", 3'd5, 32'h01, 4'h1);
    gpio = 8'h00;
    repeat (5) tick();
    rd("rd_stat_pre", 3'd4, 32'h00);
    gpio = 8'h01;
    tick();
    tick();
    wr("w1c_coinc", 3'd4, 32'h01, 4'h1);
    rd("rd_stat_coinc", 3'd4, 32'h01);

    // Reset while ack is high
    wr("w_out3c", 3'd0, 32'h3C, 4'h1);
    wr("w_en_1",  3'd3, 32'h01, 4'h1);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    exp_q.push_back(32'h3C);
    adr = 32'h0; we = 1'b0; sel = 4'h1; cyc = 1'b1; stb = 1'b1;
    tick();
    chk("pre_rst_ack", {31'd0, ack}, 32'd1);
    chk("pre_rst_dat", dat_o, exp_q.pop_front());
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", {31'd0, ack}, 32'd0);
    chk("mid_rst_dat", dat_o, 32'd0);
    chk("mid_rst_out", {24'd0, gpio_o}, 32'd0);
    chk("mid_rst_dir", {24'd0, dir_o}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rd("post_rd_out", 3'd0, 32'h00);
    wr("post_w_out", 3'd0, 32'h55, 4'h1);
    chk("post_gpio_o", {24'd0, gpio_o}, 32'h55);
    rd("post_rd_en",   3'd3, 32'h00);
    rd("post_rd_stat", 3'd4, 32'h00);
    rd("post_rd_in",   3'd2, 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
